// File: rtl/round_key_sequencer.sv
// Captures a flat AES round-key schedule and streams one 128-bit round key per
// valid/ready handshake, in forward (encrypt) or reverse (decrypt) round order.
module round_key_sequencer #(
    parameter int NK = 4,
    parameter int NR = 10,
    parameter int SW = 128*(NR+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          dir,
    input  logic [SW-1:0] sched_in,
    output logic [127:0]  rk_out,
    output logic          rk_valid,
    input  logic          rk_ready,
    output logic [3:0]    rk_round,
    output logic          rk_last,
    output logic          busy,
    output logic          done
);

    // state  | meaning
    // IDLE   | no stream; load captures schedule and direction
    // STREAM | presenting key[idx]; advances on each rk_valid & rk_ready

    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [3:0] LAST = 4'(NR);

    state_t        state, state_n;
    logic [SW-1:0] sched_q;
    logic          dir_q;
    logic [3:0]    idx, idx_n;
    logic [3:0]    count, count_n;
    logic          done_n;
    logic          capture;
    logic [127:0]  keys [0:NR];

    if (NR != NK + 6) begin : g_bad_cfg
        $error("round_key_sequencer: NR must equal NK+6");
    end

    // Round r lives in the MSB-first slice, so round 0 is the top 128 bits.
    for (genvar r = 0; r <= NR; r++) begin : g_key
        assign keys[r] = sched_q[SW-1-128*r -: 128];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sched_q <= '0;
            dir_q   <= 1'b0;
            idx     <= 4'd0;
            count   <= 4'd0;
            done    <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            count <= count_n;
            done  <= done_n;
            if (capture) begin
                sched_q <= sched_in;
                dir_q   <= dir;
            end
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        count_n = count;
        done_n  = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    capture = 1'b1;
                    idx_n   = dir ? LAST : 4'd0;
                    count_n = 4'd0;
                    state_n = STREAM;
                end
            end
            STREAM: begin
                if (rk_ready) begin
                    // idx is left on the final key so rk_out holds it after the stream.
                    if (count == LAST) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        count_n = count + 4'd1;
                        idx_n   = dir_q ? idx - 4'd1 : idx + 4'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy     = (state == STREAM);
    assign rk_valid = busy;
    assign rk_out   = keys[idx];
    assign rk_round = count;
    assign rk_last  = rk_valid & (count == LAST);

endmodule

// File: doc/round_key_sequencer.md
Name: round_key_sequencer

Overview:
- Sits directly downstream of the combinational keyExpansion stage and captures its flat round-key schedule into a register bank.
- Streams one 128-bit round key per handshake to the iterative AES round core.
- Encryption order is round 0..NR; decryption order is round NR..0.
- Decouples the wide combinational schedule from the cipher datapath and frees the key input as soon as it has been loaded.

Parameters:
- NK, 4: key length in 32-bit words (4/6/8); must match the upstream keyExpansion instance.
- NR, 10: number of rounds (10/12/14); NR == NK+6 is required, and other values are illegal/unsupported.
- SW, 128*(NR+1): schedule width (derived; not to be overridden).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- load  in  1  capture request for sched_in/dir; honoured only when busy==0
- dir  in  1  0 = forward order (encrypt), 1 = reverse order (decrypt)
- sched_in  in  SW  flat schedule from keyExpansion; round r key = sched_in[SW-1-128*r -: 128] (round 0 in MSBs)
- rk_out  out  128  current round key
- rk_valid  out  1  rk_out/rk_round/rk_last valid
- rk_ready  in  1  consumer accepts the current key
- rk_round  out  4  position in stream, 0..NR (0 = first key delivered)
- rk_last  out  1  high with the final key of the stream
- busy  out  1  stream in progress
- done  out  1  one-cycle pulse after the last key transfers

Behaviour:
- Reset: state IDLE; rk_out=0, rk_valid=0, rk_round=0, rk_last=0, busy=0, done=0; schedule register cleared. Reset wins over every other input in the same cycle.
- States: IDLE, STREAM.
- IDLE, load=1 at edge t:
  - sched_in and dir are copied into internal registers.
  - idx = dir ? NR : 0; count = 0.
  - Next state is STREAM.
  - From cycle t+1: busy=1, rk_valid=1, rk_out = key[idx], rk_round=0. Load-to-first-key latency is 1 cycle.
- STREAM, transfer (rk_valid & rk_ready):
  - count increments; idx steps +1 (dir=0) or -1 (dir=1).
  - The next key is presented the following cycle, with no bubble. Ready held high gives NR+1 keys in NR+1 consecutive cycles.
- STREAM, rk_ready=0: rk_out, rk_round and rk_last hold stable; rk_valid stays high and must not drop.
- rk_last = rk_valid & (count == NR).
- Transfer with rk_last=1:
  - Next cycle: state IDLE, rk_valid=0, busy=0, rk_last=0, done=1 for exactly one cycle.
  - rk_out keeps the last key; consumers must not sample it without rk_valid.
- load while busy=1 is ignored; sched_in and dir changes have no effect mid-stream.
- load in the done cycle is accepted, since the state is IDLE; back-to-back streams then have a 1-cycle gap.
- rst mid-stream aborts immediately: all outputs return to reset values the next cycle, and no done pulse is issued.
- idx never wraps: the stream terminates at count==NR, and idx stays within 0..NR in both directions.
- rk_out is driven from registers, never combinationally from sched_in.

Test Plan:
- Encrypt, NK=4/NR=10, key 2b7e1516_28aed2a6_abf71588_09cf4f3c, dir=0, rk_ready=1, load pulse:
  - 11 consecutive valid keys.
  - rk_round 0 = 2b7e1516..09cf4f3c; rk_round 1 = a0fafe17_88542cb1_23a33939_2a6c7605; rk_round 10 = d014f9a8_c9ee2589_e13f0cc8_b6630ca6 with rk_last=1.
  - done pulses on the next cycle.
- Decrypt order, same key, dir=1:
  - rk_round 0 = d014f9a8..b6630ca6; rk_round 10 = 2b7e1516..09cf4f3c with rk_last=1.
- AES-192, NK=6/NR=12, key 00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617:
  - dir=0: 13 keys; first = 00010203..0c0d0e0f; last = a4970a33_1a78dc09_c418c271_e3a41d5d.
  - dir=1: that order reversed.
- Backpressure: toggle rk_ready randomly.
  - rk_out/rk_round are stable whenever rk_valid&!rk_ready.
  - Exactly 11 transfers occur, in order, with no duplicate or skipped key.
- Ignored load: during stream, pulse load with a different sched_in and dir=1.
  - The stream continues unchanged.
  - A load in the done cycle starts a new stream with rk_valid high 1 cycle later.
- Reset mid-stream: assert rst after 4 transfers.
  - Next cycle: rk_valid=0, busy=0, rk_round=0, done never asserted.
  - A subsequent load restarts from rk_round 0.
